clock_div_ctrl: RTL

//  Owns the div/RST inputs of one clock_div instance; arbitrates divide-ratio change requests.
//  N_REQ requesters ask for a new ratio; round-robin grant; the block sequences a safe switch:

---
 rtl/clock_div_ctrl_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/clock_div_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/clock_div_ctrl_pkg.sv
// Shared types and constants for the clock divider ratio controller.
// Legal divider codes select /2, /4 and /8.
package clock_div_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StSettle,
    StAck,
    StNack
  } state_e;

  localparam logic [2:0] Div2 = 3'd1;
  localparam logic [2:0] Div4 = 3'd2;
  localparam logic [2:0] Div8 = 3'd4;

  function automatic logic div_legal(input logic [2:0] code);
    return (code == Div2) || (code == Div4) || (code == Div8);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i wins.
// Shared by slow-control resources that serialise requesters.
module rr_arbiter #(
  parameter int unsigned NReq = 2
) (
  input  logic [NReq-1:0] req_i,
  input  logic [2:0]      ptr_i,
  output logic [NReq-1:0] grant_o,
  output logic [2:0]      idx_o,
  output logic            valid_o
);

  always_comb begin
    int unsigned j;
    logic        found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < NReq; k++) begin
      j = (32'(ptr_i) + k) % NReq;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = 3'(j);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/clock_div_ctrl.sv
// Sole owner of one clock_div's div/RST inputs: arbitrates ratio-change requests and
// sequences each switch as reset, load, hold, release, settle, acknowledge.
module clock_div_ctrl
  import clock_div_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [2:0]  DEFAULT_DIV   = 3'd1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] req_div,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   nack,
  output logic [2:0]         div,
  output logic               div_rst,
  output logic               locked,
  output logic               busy,
  output logic [2:0]         grant_id
);

  localparam int unsigned MaxCycles = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] HoldLoad   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       div_q, div_d;
  logic             div_rst_q, div_rst_d;
  logic             locked_q, locked_d;
  logic             busy_q, busy_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] nack_q, nack_d;
  logic [2:0]       gid_q, gid_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]       ptr_q, ptr_d;
  logic             bringup_q, bringup_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [2:0]       arb_idx;
  logic             arb_valid;
  logic [2:0]       sel_code;
  logic [2:0]       ptr_next;

  rr_arbiter #(
    .NReq (N_REQ)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    sel_code = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_code = req_div[3*i +: 3];
      end
    end
    ptr_next = (arb_idx == 3'(N_REQ - 1)) ? 3'd0 : arb_idx + 3'd1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    div_rst_d = div_rst_q;
    locked_d  = locked_q;
    ack_d     = '0;
    nack_d    = '0;
    gid_d     = gid_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    bringup_d = bringup_q;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          gid_d = arb_idx;
          gnt_d = arb_gnt;
          ptr_d = ptr_next;
          if (!div_legal(sel_code)) begin
            state_d = StNack;
            nack_d  = arb_gnt;
          end else if (sel_code == div_q) begin
            // Ratio already live: acknowledge without disturbing the divider.
            state_d  = StAck;
            ack_d    = arb_gnt;
            locked_d = 1'b1;
          end else begin
            state_d   = StHold;
            div_d     = sel_code;
            div_rst_d = 1'b1;
            locked_d  = 1'b0;
            cnt_d     = HoldLoad;
          end
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d   = StSettle;
          div_rst_d = 1'b0;
          cnt_d     = SettleLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          locked_d = 1'b1;
          if (bringup_q) begin
            // Power-on bring-up has no requester to acknowledge.
            state_d   = StIdle;
            bringup_d = 1'b0;
          end else begin
            state_d = StAck;
            ack_d   = gnt_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAck:   state_d = StIdle;
      StNack:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // Reset lands directly in HOLD with the counter armed as on a normal HOLD entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StHold;
      cnt_q     <= HoldLoad;
      div_q     <= DEFAULT_DIV;
      div_rst_q <= 1'b1;
      locked_q  <= 1'b0;
      busy_q    <= 1'b1;
      ack_q     <= '0;
      nack_q    <= '0;
      gid_q     <= '0;
      gnt_q     <= '0;
      ptr_q     <= '0;
      bringup_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      div_rst_q <= div_rst_d;
      locked_q  <= locked_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      gid_q     <= gid_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      bringup_q <= bringup_d;
    end
  end

  assign ack      = ack_q;
  assign nack     = nack_q;
  assign div      = div_q;
  assign div_rst  = div_rst_q;
  assign locked   = locked_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;

endmodule
